// File: rtl/dram_write_packer_pkg.sv
// -----------------------------------------------------------------------------
// dram_write_packer_pkg
// Shared definitions for the ADC-to-DRAM write path (dram_write_packer and
// dram_varwidth): sample width, samples per RAM word, slot-select width and
// the write sequencer state encoding.
// -----------------------------------------------------------------------------
package dram_write_packer_pkg;

   localparam int WP_SAMPLE_W = 10;  // ADC sample width == RAM wr_data width
   localparam int WP_SLOTS    = 3;   // samples packed per 32-bit RAM word
   localparam int WP_WS_W     = 5;   // width of the RAM slot-select port

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_PAD     = 2'd2,
      ST_DONE    = 2'd3
   } wp_state_e;

endpackage

// File: rtl/dram_write_packer_slot.sv
// -----------------------------------------------------------------------------
// dram_slot_counter
// Holds the (word address, slot) write position of the packer.
//   clk     in   clock
//   reset   in   synchronous active-high reset (position -> 0,0)
//   clear_i in   restart at address 0, slot 0
//   inc_i   in   advance one slot (wraps into the next word)
//   slot_o  out  current slot 0..SLOTS-1
//   addr_o  out  current word address
//   wrap_o  out  current slot is the last slot of a word
//   last_o  out  current position is the final slot of the final word
// -----------------------------------------------------------------------------
module dram_slot_counter
   import dram_write_packer_pkg::*;
#(
   parameter int SLOTS       = WP_SLOTS,
   parameter int ADDR_W      = 10,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear_i,
   input  logic              inc_i,
   output logic [WP_WS_W-1:0] slot_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic              wrap_o,
   output logic              last_o
);

   logic [WP_WS_W-1:0] slot_q, slot_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;

   assign wrap_o = (slot_q == WP_WS_W'(SLOTS - 1));
   assign last_o = wrap_o && (addr_q == ADDR_W'(DEPTH_WORDS - 1));
   assign slot_o = slot_q;
   assign addr_o = addr_q;

   always_comb begin
      slot_d = slot_q;
      addr_d = addr_q;
      if (clear_i) begin
         slot_d = '0;
         addr_d = '0;
      end else if (inc_i) begin
         if (wrap_o) begin
            slot_d = '0;
            // The capture is linear: the final word never wraps back to 0.
            if (!last_o) addr_d = addr_q + 1'b1;
         end else begin
            slot_d = slot_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q <= '0;
         addr_q <= '0;
      end else begin
         slot_q <= slot_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/dram_write_packer.sv
// -----------------------------------------------------------------------------
// dram_write_packer
// Packs a stream of ADC samples SLOTS-per-word into dram_varwidth, capturing
// linearly from word 0 after arm_i. On stop (or sample limit) the last partial
// word is zero-padded so the reader only ever sees complete words.
//   wr_clk         in   sole clock (RAM write clock)
//   reset          in   synchronous active-high reset
//   arm_i          in   pulse: start capture at word 0, slot 0
//   stop_i         in   pulse: end capture (pad, then done)
//   max_samples_i  in   auto-stop after N accepted samples, 0 = until full
//   sample_i       in   ADC sample
//   sample_valid_i in   sample_i valid this cycle
//   wr_data        out  RAM write data
//   wr_addr        out  RAM word address
//   wr_ws          out  RAM slot select
//   wr_ce          out  RAM write enable, one cycle per slot write
//   words_o        out  number of completed words
//   busy_o         out  capturing or padding
//   done_o         out  capture finished
//   overflow_o     out  sticky: valid sample arrived after memory filled
// -----------------------------------------------------------------------------
module dram_write_packer
   import dram_write_packer_pkg::*;
#(
   parameter int SAMPLE_W    = WP_SAMPLE_W,
   parameter int SLOTS       = WP_SLOTS,
   parameter int ADDR_W      = 10,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                wr_clk,
   input  logic                reset,
   input  logic                arm_i,
   input  logic                stop_i,
   input  logic [ADDR_W+1:0]   max_samples_i,
   input  logic [SAMPLE_W-1:0] sample_i,
   input  logic                sample_valid_i,
   output logic [SAMPLE_W-1:0] wr_data,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [WP_WS_W-1:0]  wr_ws,
   output logic                wr_ce,
   output logic [ADDR_W:0]     words_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                overflow_o
);

   wp_state_e           state_q, state_d;
   logic [SAMPLE_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [WP_WS_W-1:0]  wr_ws_q, wr_ws_d;
   logic                wr_ce_q, wr_ce_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                ovf_q, ovf_d;
   logic                full_q, full_d;
   logic [ADDR_W+1:0]   count_q, count_d;

   logic [ADDR_W+1:0]   count_inc;
   logic                limit_now, limit_next;

   logic                cnt_clear, cnt_inc;
   logic [WP_WS_W-1:0]  cnt_slot;
   logic [ADDR_W-1:0]   cnt_addr;
   logic                cnt_wrap, cnt_last;

   dram_slot_counter #(
      .SLOTS       (SLOTS),
      .ADDR_W      (ADDR_W),
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_slot (
      .clk     (wr_clk),
      .reset   (reset),
      .clear_i (cnt_clear),
      .inc_i   (cnt_inc),
      .slot_o  (cnt_slot),
      .addr_o  (cnt_addr),
      .wrap_o  (cnt_wrap),
      .last_o  (cnt_last)
   );

   // Limit is evaluated both on the current count (no sample this cycle)
   // and on the count including a sample accepted this cycle.
   assign count_inc  = count_q + 1'b1;
   assign limit_now  = (max_samples_i != '0) && (count_q >= max_samples_i);
   assign limit_next = (max_samples_i != '0) && (count_inc >= max_samples_i);

   always_comb begin
      state_d   = state_q;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      wr_ws_d   = wr_ws_q;
      wr_ce_d   = 1'b0;
      words_d   = words_q;
      ovf_d     = ovf_q;
      full_d    = full_q;
      count_d   = count_q;
      cnt_clear = 1'b0;
      cnt_inc   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (arm_i) begin
               state_d   = ST_CAPTURE;
               cnt_clear = 1'b1;
               count_d   = '0;
               words_d   = '0;
               ovf_d     = 1'b0;
               full_d    = 1'b0;
            end
         end
         ST_CAPTURE: begin
            if (sample_valid_i) begin
               wr_ce_d   = 1'b1;
               wr_data_d = sample_i;
               wr_addr_d = cnt_addr;
               wr_ws_d   = cnt_slot;
               cnt_inc   = 1'b1;
               count_d   = count_inc;
               if (cnt_wrap) words_d = words_q + 1'b1;
               // The sample is taken first; a same-cycle stop then decides
               // whether the word it leaves behind needs padding.
               if (cnt_last) begin
                  state_d = ST_DONE;
                  full_d  = 1'b1;
               end else if (stop_i || limit_next) begin
                  state_d = cnt_wrap ? ST_DONE : ST_PAD;
               end
            end else if (stop_i || limit_now) begin
               state_d = (cnt_slot == '0) ? ST_DONE : ST_PAD;
            end
         end
         ST_PAD: begin
            wr_ce_d   = 1'b1;
            wr_data_d = '0;
            wr_addr_d = cnt_addr;
            wr_ws_d   = cnt_slot;
            cnt_inc   = 1'b1;
            if (cnt_wrap) begin
               words_d = words_q + 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (arm_i) begin
               state_d   = ST_CAPTURE;
               cnt_clear = 1'b1;
               count_d   = '0;
               words_d   = '0;
               ovf_d     = 1'b0;
               full_d    = 1'b0;
            end else if (sample_valid_i && full_q) begin
               ovf_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_CAPTURE) || (state_d == ST_PAD);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge wr_clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         wr_ws_q   <= '0;
         wr_ce_q   <= 1'b0;
         words_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
         full_q    <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
         wr_ws_q   <= wr_ws_d;
         wr_ce_q   <= wr_ce_d;
         words_q   <= words_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
         full_q    <= full_d;
         count_q   <= count_d;
      end
   end

   assign wr_data    = wr_data_q;
   assign wr_addr    = wr_addr_q;
   assign wr_ws      = wr_ws_q;
   assign wr_ce      = wr_ce_q;
   assign words_o    = words_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_dram_write_packer.sv
// -----------------------------------------------------------------------------
// tb_dram_write_packer
// Directed bench for dram_write_packer (DEPTH_WORDS = 4 so the full case is
// reachable). A sample-index model predicts every cycle's outputs; literal
// expectations pin the documented scenarios.
// -----------------------------------------------------------------------------
module tb_dram_write_packer;

   localparam int ADDR_W   = 10;
   localparam int DEPTH    = 4;
   localparam int SAMPLE_W = 10;

   logic                wr_clk = 1'b0;
   logic                reset;
   logic                arm_i, stop_i, sample_valid_i;
   logic [ADDR_W+1:0]   max_samples_i;
   logic [SAMPLE_W-1:0] sample_i;
   logic [SAMPLE_W-1:0] wr_data;
   logic [ADDR_W-1:0]   wr_addr;
   logic [4:0]          wr_ws;
   logic                wr_ce;
   logic [ADDR_W:0]     words_o;
   logic                busy_o, done_o, overflow_o;

   always #5 wr_clk = ~wr_clk;

   dram_write_packer #(
      .SAMPLE_W    (SAMPLE_W),
      .SLOTS       (3),
      .ADDR_W      (ADDR_W),
      .DEPTH_WORDS (DEPTH)
   ) dut (
      .wr_clk         (wr_clk),
      .reset          (reset),
      .arm_i          (arm_i),
      .stop_i         (stop_i),
      .max_samples_i  (max_samples_i),
      .sample_i       (sample_i),
      .sample_valid_i (sample_valid_i),
      .wr_data        (wr_data),
      .wr_addr        (wr_addr),
      .wr_ws          (wr_ws),
      .wr_ce          (wr_ce),
      .words_o        (words_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .overflow_o     (overflow_o)
   );

   int checks = 0;
   int errors = 0;

   // Model: mode 0 idle, 1 capture, 2 pad, 3 done. m_w = slots written so far.
   int m_mode, m_n, m_w, m_addr, m_ws, m_data;
   bit m_ce, m_full, m_ovf;

   // Observations of the DUT write port for literal pins.
   int wcnt, lw_addr, lw_ws, lw_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_start();
      m_mode = 1; m_n = 0; m_w = 0; m_full = 0; m_ovf = 0;
   endtask

   task automatic model_update();
      int mx;
      mx   = int'(max_samples_i);
      m_ce = 0;
      if (reset) begin
         m_mode = 0; m_n = 0; m_w = 0; m_full = 0; m_ovf = 0;
         m_addr = 0; m_ws = 0; m_data = 0;
         return;
      end
      case (m_mode)
         0: if (arm_i) model_start();
         1: begin
            if (sample_valid_i) begin
               m_ce = 1; m_addr = m_w / 3; m_ws = m_w % 3; m_data = int'(sample_i);
               m_w++; m_n++;
               if (m_w == 3 * DEPTH) begin
                  m_mode = 3; m_full = 1;
               end else if (stop_i || (mx != 0 && m_n >= mx)) begin
                  m_mode = (m_w % 3 == 0) ? 3 : 2;
               end
            end else if (stop_i || (mx != 0 && m_n >= mx)) begin
               m_mode = (m_w % 3 == 0) ? 3 : 2;
            end
         end
         2: begin
            m_ce = 1; m_addr = m_w / 3; m_ws = m_w % 3; m_data = 0;
            m_w++;
            if (m_w % 3 == 0) m_mode = 3;
         end
         default: begin
            if (arm_i) model_start();
            else if (sample_valid_i && m_full) m_ovf = 1;
         end
      endcase
   endtask

   task automatic compare();
      chk("wr_ce", 32'(wr_ce), 32'(m_ce));
      if (m_ce) begin
         chk("wr_addr", 32'(wr_addr), 32'(m_addr));
         chk("wr_ws",   32'(wr_ws),   32'(m_ws));
         chk("wr_data", 32'(wr_data), 32'(m_data));
      end
      chk("words_o",    32'(words_o),    32'(m_w / 3));
      chk("busy_o",     32'(busy_o),     32'(m_mode == 1 || m_mode == 2));
      chk("done_o",     32'(done_o),     32'(m_mode == 3));
      chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
      if (wr_ce) begin
         wcnt++; lw_addr = int'(wr_addr); lw_ws = int'(wr_ws); lw_data = int'(wr_data);
      end
   endtask

   task automatic step(input logic a, input logic st, input logic v,
                       input logic [SAMPLE_W-1:0] s, input logic rs);
      arm_i = a; stop_i = st; sample_valid_i = v; sample_i = s; reset = rs;
      model_update();
      @(posedge wr_clk);
      #1;
      compare();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'h000, 1'b0);
   endtask

   task automatic valid(input logic [SAMPLE_W-1:0] s);
      step(1'b0, 1'b0, 1'b1, s, 1'b0);
   endtask

   task automatic arm();
      wcnt = 0;
      step(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);
   endtask

   initial begin
      arm_i = 0; stop_i = 0; sample_valid_i = 0; sample_i = '0; reset = 1;
      max_samples_i = '0;
      m_mode = 0; m_n = 0; m_w = 0; m_addr = 0; m_ws = 0; m_data = 0;
      m_ce = 0; m_full = 0; m_ovf = 0; wcnt = 0; lw_addr = 0; lw_ws = 0; lw_data = 0;

      // Reset state
      step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
      step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
      chk("rst_outputs", {wr_data, wr_addr, wr_ws, wr_ce, words_o, busy_o, done_o, overflow_o} == '0, 1);
      idle(2);

      // 1: three samples fill word 0, each written one cycle after its valid
      arm();
      valid(10'h1AA);
      chk("t1_latency_ce", 32'(wr_ce), 1);
      chk("t1_latency_data", 32'(wr_data), 32'h1AA);
      valid(10'h1BC);
      valid(10'h2DA);
      chk("t1_words", 32'(words_o), 1);
      chk("t1_last", {lw_addr[15:0], lw_ws[7:0], lw_data[11:0]}, {16'd0, 8'd2, 12'h2DA});
      step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);  // stop on a word boundary: no pad
      chk("t1_done", 32'(done_o), 1);
      chk("t1_wcnt", 32'(wcnt), 3);
      idle(1);

      // 2: four samples then stop -> two pad writes
      arm();
      valid(10'h32A); valid(10'h444); valid(10'h555); valid(10'h175);
      step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
      idle(3);
      chk("t2_wcnt", 32'(wcnt), 6);
      chk("t2_last", {lw_addr[15:0], lw_ws[7:0], lw_data[11:0]}, {16'd1, 8'd2, 12'h000});
      chk("t2_words", 32'(words_o), 2);
      chk("t2_done", 32'(done_o), 1);

      // 3: limit of 5 samples, eight valids offered
      max_samples_i = 12'd5;
      arm();
      for (int i = 1; i <= 8; i++) valid(SAMPLE_W'(10'h100 + i));
      idle(2);
      chk("t3_wcnt", 32'(wcnt), 6);
      chk("t3_last", {lw_addr[15:0], lw_ws[7:0], lw_data[11:0]}, {16'd1, 8'd2, 12'h000});
      chk("t3_done", 32'(done_o), 1);
      chk("t3_ovf", 32'(overflow_o), 0);
      max_samples_i = '0;

      // 4: fill all four words, then one extra valid -> overflow
      arm();
      for (int i = 1; i <= 13; i++) valid(SAMPLE_W'(i));
      idle(1);
      chk("t4_wcnt", 32'(wcnt), 12);
      chk("t4_last", {lw_addr[15:0], lw_ws[7:0], lw_data[11:0]}, {16'd3, 8'd2, 12'h00C});
      chk("t4_words", 32'(words_o), 4);
      chk("t4_done", 32'(done_o), 1);
      chk("t4_ovf", 32'(overflow_o), 1);

      // 5: reset mid-capture at (2,1), then re-arm
      arm();
      chk("t5_arm_clears_ovf", 32'(overflow_o), 0);
      for (int i = 0; i < 7; i++) valid(SAMPLE_W'(10'h050 + i));
      step(1'b0, 1'b0, 1'b0, 10'h000, 1'b1);
      chk("t5_rst_outputs", {wr_data, wr_addr, wr_ws, wr_ce, words_o, busy_o, done_o, overflow_o} == '0, 1);
      wcnt = 0;
      idle(3);
      chk("t5_no_pad", 32'(wcnt), 0);
      arm();
      valid(10'h3FF);
      chk("t5_first", {32'(wr_ce), 32'(wr_addr), 32'(wr_ws)}, {32'd1, 32'd0, 32'd0});
      step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
      idle(3);

      // 6: stop together with the slot-2 sample -> written, no pad
      arm();
      valid(10'h0A1); valid(10'h0B2);
      step(1'b0, 1'b1, 1'b1, 10'h0C3, 1'b0);
      chk("t6_write", {lw_addr[15:0], lw_ws[7:0], lw_data[11:0]}, {16'd0, 8'd2, 12'h0C3});
      chk("t6_done", 32'(done_o), 1);
      idle(2);
      chk("t6_wcnt", 32'(wcnt), 3);
      chk("t6_words", 32'(words_o), 1);

      // Stop in DONE is ignored; arm in CAPTURE is ignored
      step(1'b0, 1'b1, 1'b0, 10'h000, 1'b0);
      arm();
      valid(10'h011);
      step(1'b1, 1'b0, 1'b1, 10'h022, 1'b0);
      chk("arm_in_capture_ws", 32'(wr_ws), 1);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
